// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared types and constants for the SPART host bridge
package spart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_GAP  = 2'd2
  } bus_state_t;

  localparam logic [1:0] IOADDR_DATA   = 2'b00;
  localparam logic [1:0] IOADDR_STATUS = 2'b11;
  localparam logic [3:0] RX_TERM_TAG   = 4'hF;
  localparam int         RX_SLOTS      = 16;

endpackage

// File: rtl/spart_tx_fifo.sv
// rtl/spart_tx_fifo.sv - synchronous TX FIFO with occupancy, threshold and drop flags
module spart_tx_fifo #(
  parameter int TX_DEPTH    = 16,
  parameter int TX_AF_LEVEL = TX_DEPTH - 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [7:0]                  din,
  input  logic                        pop,
  output logic [7:0]                  head,
  output logic                        empty,
  output logic                        full,
  output logic                        afull,
  output logic [$clog2(TX_DEPTH):0]   count,
  output logic                        drop
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // A push into a full FIFO is only safe when the head leaves this same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign empty = (count == '0);
  assign full  = (count == CW'(TX_DEPTH));
  assign afull = (count >= CW'(TX_AF_LEVEL));
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      drop <= push && !push_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spart_host_bridge.sv
// rtl/spart_host_bridge.sv - host-side SPART driver: TX FIFO, bus FSM, RX frame assembly
module spart_host_bridge
  import spart_pkg::*;
#(
  parameter int TX_DEPTH    = 16,
  parameter int TX_AF_LEVEL = TX_DEPTH - 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        iorw,
  output logic [1:0]                  ioaddr,
  inout  wire  [7:0]                  databus,
  input  logic                        rda,
  input  logic                        tbr,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_wr,
  output logic                        tx_full,
  output logic                        tx_afull,
  output logic [$clog2(TX_DEPTH):0]   tx_count,
  output logic                        tx_drop,
  input  logic [1:0]                  rx_addr,
  output logic [15:0]                 rx_word,
  output logic                        rx_rdy,
  input  logic                        rx_ack,
  output logic                        rx_ovr
);

  bus_state_t state;
  bus_state_t state_nxt;

  logic       fifo_empty;
  logic       fifo_pop;
  logic [7:0] fifo_head;
  logic       capture;
  logic       rx_term;

  logic [3:0] work     [RX_SLOTS];
  logic [3:0] work_nxt [RX_SLOTS];
  logic [3:0] frame    [RX_SLOTS];

  spart_tx_fifo #(
    .TX_DEPTH    (TX_DEPTH),
    .TX_AF_LEVEL (TX_AF_LEVEL)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_wr),
    .din   (tx_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .empty (fifo_empty),
    .full  (tx_full),
    .afull (tx_afull),
    .count (tx_count),
    .drop  (tx_drop)
  );

  // Bus is driven only in WR; reset forces IDLE asynchronously, releasing it at once.
  assign databus = iorw ? {8{1'bz}} : fifo_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    iorw      = 1'b1;
    ioaddr    = IOADDR_STATUS;
    fifo_pop  = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rda) begin
          ioaddr  = IOADDR_DATA;
          capture = 1'b1;
        end else if (tbr && !fifo_empty) begin
          state_nxt = ST_WR;
        end
      end
      ST_WR: begin
        iorw      = 1'b0;
        ioaddr    = IOADDR_DATA;
        fifo_pop  = 1'b1;
        state_nxt = ST_GAP;
      end
      ST_GAP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign rx_term = capture && (databus[7:4] == RX_TERM_TAG);

  // Working buffer as it stands after this cycle's capture; the frame copy uses it
  // so the terminator's own nibble lands in slot 15 of the published frame.
  always_comb begin
    for (int i = 0; i < RX_SLOTS; i++) begin
      work_nxt[i] = work[i];
    end
    if (capture) begin
      work_nxt[databus[7:4]] = databus[3:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RX_SLOTS; i++) begin
        work[i]  <= 4'h0;
        frame[i] <= 4'h0;
      end
      rx_rdy <= 1'b0;
      rx_ovr <= 1'b0;
    end else begin
      for (int i = 0; i < RX_SLOTS; i++) begin
        work[i] <= work_nxt[i];
      end
      if (rx_term) begin
        for (int i = 0; i < RX_SLOTS; i++) begin
          frame[i] <= work_nxt[i];
        end
      end
      if (rx_ack) begin
        rx_rdy <= rx_term;
        rx_ovr <= 1'b0;
      end else if (rx_term) begin
        rx_rdy <= 1'b1;
        if (rx_rdy) begin
          rx_ovr <= 1'b1;
        end
      end
    end
  end

  assign rx_word = {frame[{rx_addr, 2'd0}], frame[{rx_addr, 2'd1}],
                    frame[{rx_addr, 2'd2}], frame[{rx_addr, 2'd3}]};

endmodule

// File: tb/tb_spart_host_bridge.sv
// tb/tb_spart_host_bridge.sv - directed self-checking bench for spart_host_bridge
module tb_spart_host_bridge;

  logic        clk;
  logic        rst;
  logic        iorw;
  logic [1:0]  ioaddr;
  wire  [7:0]  databus;
  logic        rda;
  logic        tbr;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_full;
  logic        tx_afull;
  logic [4:0]  tx_count;
  logic        tx_drop;
  logic [1:0]  rx_addr;
  logic [15:0] rx_word;
  logic        rx_rdy;
  logic        rx_ack;
  logic        rx_ovr;

  logic        tb_en;
  logic [7:0]  tb_byte;

  int n_checks;
  int n_fail;

  assign databus = tb_en ? tb_byte : {8{1'bz}};

  spart_host_bridge #(.TX_DEPTH(16), .TX_AF_LEVEL(14)) dut (
    .clk      (clk),
    .rst      (rst),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .rda      (rda),
    .tbr      (tbr),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_full  (tx_full),
    .tx_afull (tx_afull),
    .tx_count (tx_count),
    .tx_drop  (tx_drop),
    .rx_addr  (rx_addr),
    .rx_word  (rx_word),
    .rx_rdy   (rx_rdy),
    .rx_ack   (rx_ack),
    .rx_ovr   (rx_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rda     = 1'b1;
    tb_en   = 1'b1;
    tb_byte = b;
    tick();
    rda   = 1'b0;
    tb_en = 1'b0;
  endtask

  task automatic word_at(input logic [1:0] a, input string tag, input logic [15:0] exp);
    rx_addr = a;
    #1;
    check(tag, rx_word, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; rda = 1'b0; tbr = 1'b0; tx_data = 8'h00; tx_wr = 1'b0;
    rx_addr = 2'd0; rx_ack = 1'b0; tb_en = 1'b0; tb_byte = 8'h00;
    tick();
    tick();
    check("rst_iorw",   {15'd0, iorw}, 16'd1);
    check("rst_ioaddr", {14'd0, ioaddr}, 16'd3);
    check("rst_count",  {11'd0, tx_count}, 16'd0);
    check("rst_flags",  {12'd0, tx_full, tx_afull, tx_drop, rx_rdy}, 16'd0);
    check("rst_ovr",    {15'd0, rx_ovr}, 16'd0);
    check("rst_word",   rx_word, 16'h0000);
    rst = 1'b0;
    tick();

    // two pushes back to back, transmitter ready
    tbr = 1'b1; tx_wr = 1'b1; tx_data = 8'h41;
    tick();
    check("tx1_count", {11'd0, tx_count}, 16'd1);
    check("tx1_iorw",  {15'd0, iorw}, 16'd1);
    tx_data = 8'h42;
    tick();
    tx_wr = 1'b0;
    check("wr1_iorw",   {15'd0, iorw}, 16'd0);
    check("wr1_ioaddr", {14'd0, ioaddr}, 16'd0);
    check("wr1_data",   {8'd0, databus}, 16'h0041);
    check("wr1_count",  {11'd0, tx_count}, 16'd2);
    tick();
    check("gap_iorw",   {15'd0, iorw}, 16'd1);
    check("gap_ioaddr", {14'd0, ioaddr}, 16'd3);
    check("gap_count",  {11'd0, tx_count}, 16'd1);
    tick();
    check("idle_iorw",  {15'd0, iorw}, 16'd1);
    tick();
    check("wr2_iorw",   {15'd0, iorw}, 16'd0);
    check("wr2_data",   {8'd0, databus}, 16'h0042);
    tick();
    check("wr2_count",  {11'd0, tx_count}, 16'd0);
    tick();
    check("empty_iorw", {15'd0, iorw}, 16'd1);
    tbr = 1'b0;

    // receive a frame
    rx_byte(8'h0A);
    for (int i = 1; i < 15; i++) begin
      rx_byte({i[3:0], 4'h1});
    end
    check("pre_term_rdy", {15'd0, rx_rdy}, 16'd0);
    rx_byte(8'hF5);
    check("f1_rdy", {15'd0, rx_rdy}, 16'd1);
    check("f1_ovr", {15'd0, rx_ovr}, 16'd0);
    word_at(2'd0, "f1_w0", 16'hA111);
    word_at(2'd1, "f1_w1", 16'h1111);
    word_at(2'd3, "f1_w3", 16'h1115);

    // overrun: second frame without ack
    rx_byte(8'h03);
    rx_byte(8'hF7);
    check("f2_rdy", {15'd0, rx_rdy}, 16'd1);
    check("f2_ovr", {15'd0, rx_ovr}, 16'd1);
    word_at(2'd0, "f2_w0", 16'h3111);
    word_at(2'd3, "f2_w3", 16'h1117);
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    check("ack_rdy", {15'd0, rx_rdy}, 16'd0);
    check("ack_ovr", {15'd0, rx_ovr}, 16'd0);

    // terminator coinciding with ack
    rx_byte(8'hF2);
    rx_byte(8'hF4);
    check("f4_ovr", {15'd0, rx_ovr}, 16'd1);
    rx_ack = 1'b1;
    rx_byte(8'hF9);
    rx_ack = 1'b0;
    check("tack_rdy", {15'd0, rx_rdy}, 16'd1);
    check("tack_ovr", {15'd0, rx_ovr}, 16'd0);
    word_at(2'd3, "tack_w3", 16'h1119);

    // fill the FIFO with the transmitter stalled
    for (int i = 0; i < 16; i++) begin
      tx_wr = 1'b1;
      tx_data = 8'h10 + 8'(i);
      tick();
      if (i == 12) check("af_13", {15'd0, tx_afull}, 16'd0);
      if (i == 13) check("af_14", {15'd0, tx_afull}, 16'd1);
      if (i == 14) check("full_15", {15'd0, tx_full}, 16'd0);
    end
    check("fill_count", {11'd0, tx_count}, 16'd16);
    check("fill_full",  {15'd0, tx_full}, 16'd1);
    check("fill_drop",  {15'd0, tx_drop}, 16'd0);
    tx_data = 8'h99;
    tick();
    tx_wr = 1'b0;
    check("drop_pulse", {15'd0, tx_drop}, 16'd1);
    check("drop_count", {11'd0, tx_count}, 16'd16);
    tick();
    check("drop_clear", {15'd0, tx_drop}, 16'd0);

    // push while full, accepted because WR pops the same cycle
    tbr = 1'b1;
    tick();
    check("fp_iorw", {15'd0, iorw}, 16'd0);
    check("fp_data", {8'd0, databus}, 16'h0010);
    tx_wr = 1'b1; tx_data = 8'hAA;
    tick();
    tx_wr = 1'b0;
    check("fp_count", {11'd0, tx_count}, 16'd16);
    check("fp_drop",  {15'd0, tx_drop}, 16'd0);

    // rda and tbr both high in GAP then IDLE
    rda = 1'b1; tb_en = 1'b1; tb_byte = 8'h0B;
    #1;
    check("gap_rda_ioaddr", {14'd0, ioaddr}, 16'd3);
    tick();
    check("pri_iorw",   {15'd0, iorw}, 16'd1);
    check("pri_ioaddr", {14'd0, ioaddr}, 16'd0);
    tick();
    rda = 1'b0; tb_en = 1'b0;
    #1;
    check("pri_idle_ioaddr", {14'd0, ioaddr}, 16'd3);
    tick();
    check("pri_wr_iorw", {15'd0, iorw}, 16'd0);
    check("pri_wr_data", {8'd0, databus}, 16'h0011);
    tbr = 1'b0;
    tick();
    tick();
    rx_ack = 1'b1;
    rx_byte(8'hF0);
    rx_ack = 1'b0;
    word_at(2'd0, "pri_w0", 16'hB111);
    word_at(2'd3, "pri_w3", 16'h1110);

    // asynchronous reset in the middle of WR
    tbr = 1'b1;
    tick();
    check("rw_iorw", {15'd0, iorw}, 16'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_iorw",   {15'd0, iorw}, 16'd1);
    check("arst_ioaddr", {14'd0, ioaddr}, 16'd3);
    check("arst_count",  {11'd0, tx_count}, 16'd0);
    check("arst_flags",  {12'd0, tx_full, tx_afull, tx_drop, rx_rdy}, 16'd0);
    check("arst_word",   rx_word, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_iorw", {15'd0, iorw}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
